// File: rtl/cmp_sweep_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : cmp_sweep_checker_if
// Purpose  : Operand/colour bundle between the sweep checker and the
//            comparator-to-RGB block under test.
// Revision : 1.0 - initial release
// ============================================================================
interface cmp_sweep_checker_if #(
  parameter int W = 2
);
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         red;
  logic         green;
  logic         blue;

  // Checker side: drives operands, samples colours
  modport master (output a, b, input red, green, blue);
  // Colour block side: consumes operands, drives colours
  modport slave  (input a, b, output red, green, blue);
endinterface
`default_nettype wire

// File: rtl/cmp_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : cmp_sweep_checker
// Purpose  : Sweeps every (a,b) operand pair into a magnitude-compare colour
//            block, checks the one-hot red/green/blue answer on the last
//            hold cycle of each pair and reports pass / error count / first
//            failing pair.
// Revision : 1.0 - initial release
// ============================================================================
module cmp_sweep_checker #(
  parameter int W           = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             start,
  cmp_sweep_checker_if.master   cif,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [2*W:0]          err_count,
  output logic                  fail_valid,
  output logic [W-1:0]          fail_a,
  output logic [W-1:0]          fail_b
);

  localparam int              HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0]   HOLD_ONE  = HW'(1);
  localparam logic [2*W:0]    ERR_MAX   = {1'b1, {(2*W){1'b0}}};
  localparam logic [2*W:0]    ERR_ONE   = (2*W+1)'(1);
  localparam logic [2*W-1:0]  PAIR_ONE  = (2*W)'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]     r_state;
  logic [HW-1:0]  r_hold;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;

  logic [2:0]     w_expect;
  logic [2:0]     w_resp;
  logic           w_mismatch;
  logic           w_sample;
  logic           w_last_pair;
  logic [2*W-1:0] w_pair_next;

  assign cif.a = r_a;
  assign cif.b = r_b;

  // Expected colour for the current pair and the mismatch / sample decode
  always_comb begin
    w_expect    = {r_a > r_b, r_a == r_b, r_a < r_b};
    w_resp      = {cif.red, cif.green, cif.blue};
    w_mismatch  = (w_resp != w_expect);
    w_sample    = (r_state == ST_RUN) && (r_hold == HOLD_LAST);
    w_last_pair = (&r_a) && (&r_b);
    // b is the low half so it advances first and carries into a
    w_pair_next = {r_a, r_b} + PAIR_ONE;
  end

  // Sweep FSM, operand sequencing and result bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_hold     <= '0;
      r_a        <= '0;
      r_b        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_state    <= ST_RUN;
            r_hold     <= '0;
            r_a        <= '0;
            r_b        <= '0;
            busy       <= 1'b1;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
          end
        end

        ST_RUN: begin
          if (w_sample) begin
            if (w_mismatch) begin
              if (err_count != ERR_MAX) begin
                err_count <= err_count + ERR_ONE;
              end
              if (!fail_valid) begin
                fail_valid <= 1'b1;
                fail_a     <= r_a;
                fail_b     <= r_b;
              end
            end
            r_hold       <= '0;
            // After the final pair this wraps both operands back to zero
            {r_a, r_b}   <= w_pair_next;
            if (w_last_pair) begin
              r_state <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (err_count == '0) && !w_mismatch;
            end
          end else begin
            r_hold <= r_hold + HOLD_ONE;
          end
        end

        ST_DONE: begin
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmp_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmp_sweep_checker
// Purpose  : Scoreboard bench for cmp_sweep_checker with a table-driven
//            colour block (golden or faulty) and randomised fault patterns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmp_sweep_checker;

  localparam int W    = 2;
  localparam int HOLD = 4;
  localparam int N    = 1 << W;
  localparam int NP   = N * N;

  typedef struct packed {
    logic [2*W:0] err;
    logic         fv;
    logic [W-1:0] fa;
    logic [W-1:0] fb;
    logic         pass;
  } sum_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy, done, pass, fail_valid;
  logic [2*W:0] err_count;
  logic [W-1:0] fail_a, fail_b;

  logic [2:0]     resp [NP];
  sum_t           exp_sum [$];
  logic [2*W-1:0] exp_pair [$];
  sum_t           last_sum;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cmp_sweep_checker_if #(.W(W)) bus ();

  // Colour block model: response looked up per operand pair
  assign {bus.red, bus.green, bus.blue} = resp[{bus.a, bus.b}];

  cmp_sweep_checker #(.W(W), .HOLD_CYCLES(HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cif        (bus.master),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .fail_valid (fail_valid),
    .fail_a     (fail_a),
    .fail_b     (fail_b)
  );

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] rule(input int a, input int b);
    if (a > b)       return 3'b100;
    else if (a == b) return 3'b010;
    else             return 3'b001;
  endfunction

  // Fill the colour table: 0 golden, 1 red/green swapped, 2 blue stuck high,
  // 3 pair (2,3) silent, 4 one random pair random pattern, 5 random corruption
  task automatic set_mode(input int mode);
    int k;
    for (int i = 0; i < NP; i++) begin
      logic [2:0] r;
      r = rule(i / N, i % N);
      case (mode)
        1: resp[i] = {r[1], r[2], r[0]};
        2: resp[i] = r | 3'b001;
        3: resp[i] = ((i / N) == 2 && (i % N) == 3) ? 3'b000 : r;
        5: resp[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : r;
        default: resp[i] = r;
      endcase
    end
    if (mode == 4) begin
      k = $urandom_range(0, NP - 1);
      resp[k] = 3'($urandom_range(0, 7));
    end
  endtask

  // Reference: walk pairs in sweep order and judge each table entry by the rule
  task automatic push_expected();
    sum_t s;
    int errs;
    s    = '0;
    errs = 0;
    for (int i = 0; i < NP; i++) begin
      if (resp[i] != rule(i / N, i % N)) begin
        if (errs == 0) begin
          s.fv = 1'b1;
          s.fa = W'(i / N);
          s.fb = W'(i % N);
        end
        errs++;
      end
      for (int h = 0; h < HOLD; h++) exp_pair.push_back((2*W)'(i));
    end
    s.err    = (2*W+1)'(errs);
    s.pass   = (errs == 0);
    last_sum = s;
    exp_sum.push_back(s);
  endtask

  // Monitor: pops expected pairs while busy and the summary on done
  int run_cycles = 0;
  bit prev_done  = 1'b0;
  always @(negedge clk) begin
    sum_t s;
    logic [2*W-1:0] p;
    if (rst) begin
      run_cycles = 0;
      prev_done  = 1'b0;
    end else begin
      if (prev_done) check("done_pulse_width", done, 0);
      prev_done = done;
      if (busy) begin
        run_cycles++;
        if (exp_pair.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_busy: got busy=1 expected 0 at %0t", $time);
        end else begin
          p = exp_pair.pop_front();
          check("pair_ab", {bus.a, bus.b}, p);
        end
      end else begin
        check("idle_ab_zero", {bus.a, bus.b}, 0);
      end
      if (done) begin
        if (exp_sum.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done=1 expected 0 at %0t", $time);
        end else begin
          s = exp_sum.pop_front();
          check("err_count",   err_count,  s.err);
          check("fail_valid",  fail_valid, s.fv);
          check("fail_a",      fail_a,     s.fa);
          check("fail_b",      fail_b,     s.fb);
          check("pass",        pass,       s.pass);
          check("busy_cycles", run_cycles, NP * HOLD);
          check("busy_at_done", busy, 0);
        end
        run_cycles = 0;
      end
    end
  end

  task automatic run_sweep(input int mode, input bit repulse);
    int lat;
    bit got;
    set_mode(mode);
    push_expected();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= NP * HOLD + 20; k++) begin
      @(posedge clk); #2;
      start = (repulse && k == 20);
      if (done) begin
        got = 1'b1;
        lat = k;
        break;
      end
    end
    start = 1'b0;
    if (!got) begin
      tests++; fails++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", NP * HOLD + 20);
      exp_pair.delete();
      exp_sum.delete();
    end else begin
      // cycle 1 is the first busy cycle after the accepting edge
      check("done_cycle", lat + 1, NP * HOLD + 1);
    end
    repeat (3) @(posedge clk);
    #2;
    check("held_err_count",  err_count,  last_sum.err);
    check("held_fail_valid", fail_valid, last_sum.fv);
    check("held_pass",       pass,       last_sum.pass);
  endtask

  task automatic reset_test();
    bit hit;
    int seen;
    set_mode(2);
    push_expected();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < NP * HOLD + 20; k++) begin
      @(posedge clk); #2;
      if (bus.a == 2 && bus.b == 1) begin
        hit = 1'b1;
        break;
      end
    end
    check("reached_pair_2_1", hit, 1);
    // Pairs (0,0),(1,0),(1,1),(2,0) already judged wrong under blue-stuck
    check("pre_reset_err", err_count, 4);
    rst = 1'b1;
    @(posedge clk); #2;
    exp_pair.delete();
    exp_sum.delete();
    check("rst_busy",       busy,       0);
    check("rst_done",       done,       0);
    check("rst_pass",       pass,       0);
    check("rst_err_count",  err_count,  0);
    check("rst_fail_valid", fail_valid, 0);
    check("rst_fail_ab",    {fail_a, fail_b}, 0);
    check("rst_ab",         {bus.a, bus.b},   0);
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #2;
      if (done || busy) seen++;
    end
    check("no_activity_after_reset", seen, 0);
  endtask

  // Stimulus driver
  initial begin
    rst   = 1'b1;
    start = 1'b0;
    set_mode(0);
    repeat (3) @(posedge clk);
    #2;
    check("init_busy",       busy,       0);
    check("init_done",       done,       0);
    check("init_err_count",  err_count,  0);
    check("init_fail_valid", fail_valid, 0);
    check("init_pass",       pass,       0);
    check("init_ab",         {bus.a, bus.b}, 0);
    rst = 1'b0;

    run_sweep(0, 1'b0);
    run_sweep(1, 1'b0);
    run_sweep(2, 1'b0);
    run_sweep(3, 1'b0);
    run_sweep(0, 1'b1);
    for (int s = 0; s < 6; s++) begin
      run_sweep($urandom_range(0, 5), 1'($urandom_range(0, 1)));
    end
    reset_test();
    run_sweep(0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
